digits_to_num: RTL and testbench
================================

Name: digits_to_num

Overview:
- Reverse path of the number-to-digits display converter.
- Collects decimal digits entered one at a time from a keypad or switch front end into an NDIG-digit entry buffer.
- The buffer drives the 7-seg digit array directly, so leading positions show as blank.
- On a convert strobe, a sequential multiply-accumulate (×10 + digit, one digit per cycle) produces a binary value for the core FSM.

Parameters:
- NDIG, 4, number of digit positions.
- WIDTH, 32, width of the binary result.
- BLANK, 4'hb, code stored in unentered positions (same blank code the display decoder uses).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- digit_in  input  4  BCD digit to enter.
- digit_valid  input  1  one-cycle strobe qualifying digit_in.
- backspace  input  1  strobe; removes the most recently entered digit.
- clear  input  1  strobe; empties the buffer and aborts any conversion.
- convert  input  1  strobe; starts a conversion.
- digit_array  output  4 x NDIG  entry buffer; [0] is the least-significant (most recent) digit.
- count  output  $clog2(NDIG+1)  number of digits entered.
- busy  output  1  conversion in progress.
- number  output  WIDTH  last conversion result, held until the next one.
- num_valid  output  1  one-cycle pulse when number updates.
- err  output  1  sticky entry-error flag.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - every digit_array entry = BLANK
  - count = 0, number = 0, num_valid = 0, busy = 0, err = 0
  - state = IDLE
- States: IDLE, CONV. busy = (state == CONV).
- IDLE input priority within one cycle: clear > convert > backspace > digit_valid. Lower-priority strobes in the same cycle are dropped.
- Digit entry (digit_valid):
  - If digit_in ≤ 9 and count < NDIG: shift the buffer up ([k] <= [k-1]), set [0] <= digit_in, count++.
  - If digit_in > 9, or count == NDIG: buffer unchanged, err <= 1.
- backspace:
  - If count > 0: shift the buffer down ([k-1] <= [k]), set [NDIG-1] <= BLANK, count--.
  - If count == 0: no-op, err unaffected.
- clear: all entries <= BLANK, count <= 0, err <= 0, state <= IDLE. It is honoured in every state. Clear in CONV discards the accumulator and no num_valid is produced.
- convert accepted at edge E0: acc <= 0, idx <= NDIG-1, state <= CONV. count == 0 is legal.
- CONV, edges E1..E_NDIG:
  - acc <= acc*10 + d, where d = digit_array[idx], or 0 if that entry is BLANK.
  - idx <= idx - 1.
  - At edge E_NDIG: number <= final acc, num_valid <= 1 for exactly one cycle, state <= IDLE.
- Timing:
  - Latency: num_valid is high NDIG cycles after the convert edge.
  - busy is high for NDIG cycles.
  - The buffer is unchanged by a conversion, so a repeated convert gives the same number.
- Inputs in CONV: digit_valid, backspace and convert are ignored (no error, not queued). Only clear acts.
- Arithmetic:
  - acc is WIDTH bits; ×10 is computed as (acc<<3)+(acc<<1); overflow wraps modulo 2^WIDTH.
  - Maximum for NDIG=4 is 9999, so no overflow at the defaults.
- Reset asserted mid-conversion: immediate return to reset values; num_valid is not asserted.

Optional Feature:
- Macro: DIGITS_TO_NUM_SENTINEL_EN.
- Defined: a convert with count == 0 completes with the same NDIG-cycle latency but sets number <= {WIDTH{1'b1}} - 1 (i.e. -2, the "wait/blank" display code), so a round trip through the display converter shows all blanks.
- Undefined: an empty buffer converts to 0.

Decomposition:
- Package digits_pkg holds:
  - BLANK_CODE = 4'hb and H_CODE = 4'ha
  - NUM_INIT = -1 and NUM_WAIT = -2
  - the dtn_state_t enum {IDLE, CONV}
- It is shared with the existing number-to-digits converter.
- One natural combinational sub-module, bcd_mac_step: inputs acc[WIDTH] and d[4], output acc*10 + (d == BLANK_CODE ? 0 : d).

Test Plan:
- Enter 1,2,3,4 then convert → digit_array = {1,2,3,4} (from [3] down to [0]); busy high for 4 cycles; num_valid pulses once, 4 cycles after convert; number = 1234.
- Enter 7 then convert → digit_array = {B,B,B,7}, count = 1, number = 7. A second convert → number = 7 again, with a second num_valid pulse.
- Enter 9,8,7,6,5 → the 5th digit is ignored, err = 1, buffer = 9876. Then enter 4'hc → buffer unchanged, err stays 1. Then clear → all B, count = 0, err = 0.
- Enter 4,2, backspace, 3, convert → number = 43. Backspace at count 0 → no change.
- Enter 5,5, convert, clear 2 cycles later → no num_valid, number keeps its previous value, buffer blank. Repeat with rst_n low mid-CONV → all outputs at reset values.
- Convert with an empty buffer → number = 0 without the macro; number = 32'hFFFF_FFFE with DIGITS_TO_NUM_SENTINEL_EN defined.

Source files
------------

// File: rtl/digits_pkg.sv
// Codes and state type shared by the digit-entry converter and the number-to-digits display converter.
package digits_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hb;
    localparam logic [3:0] H_CODE     = 4'ha;
    localparam int         NUM_INIT   = -1;
    localparam int         NUM_WAIT   = -2;

    typedef enum logic {IDLE, CONV} dtn_state_t;

endpackage

// File: rtl/bcd_mac_step.sv
// One step of decimal-to-binary accumulation: acc*10 + digit, with blank positions counting as zero.
module bcd_mac_step
    import digits_pkg::*;
#(
    parameter int         WIDTH = 32,
    parameter logic [3:0] BLANK = BLANK_CODE
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [3:0]       d,
    output logic [WIDTH-1:0] acc_next
);

    logic [3:0] d_eff;

    assign d_eff    = (d == BLANK) ? 4'd0 : d;
    assign acc_next = (acc << 3) + (acc << 1) + WIDTH'(d_eff);

endmodule

// File: rtl/digits_to_num.sv
// Keypad digit-entry buffer plus sequential BCD-to-binary conversion, one digit per clock.
// Build option: DIGITS_TO_NUM_SENTINEL_EN makes an empty buffer convert to the display "wait" code.
module digits_to_num
    import digits_pkg::*;
#(
    parameter int         NDIG  = 4,
    parameter int         WIDTH = 32,
    parameter logic [3:0] BLANK = BLANK_CODE
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [3:0]                 digit_in,
    input  logic                       digit_valid,
    input  logic                       backspace,
    input  logic                       clear,
    input  logic                       convert,
    output logic [NDIG-1:0][3:0]       digit_array,
    output logic [$clog2(NDIG+1)-1:0]  count,
    output logic                       busy,
    output logic [WIDTH-1:0]           number,
    output logic                       num_valid,
    output logic                       err
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CW = $clog2(NDIG+1);

    dtn_state_t       state, state_next;
    logic [WIDTH-1:0] acc, acc_next;
    logic [IW-1:0]    idx;
    logic             last;

    // Walk from the most-significant position [NDIG-1] down to [0].
    bcd_mac_step #(.WIDTH(WIDTH), .BLANK(BLANK)) u_mac (
        .acc      (acc),
        .d        (digit_array[idx]),
        .acc_next (acc_next)
    );

    assign busy = (state == CONV);

    always_comb begin
        state_next = state;
        last       = 1'b0;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (convert) state_next = CONV;
                CONV: if (idx == '0) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_array <= {NDIG{BLANK}};
            count       <= '0;
            err         <= 1'b0;
            number      <= '0;
            num_valid   <= 1'b0;
            acc         <= '0;
            idx         <= '0;
        end else begin
            num_valid <= 1'b0;
            if (clear) begin
                digit_array <= {NDIG{BLANK}};
                count       <= '0;
                err         <= 1'b0;
            end else if (state == IDLE) begin
                if (convert) begin
                    acc <= '0;
                    idx <= IW'(NDIG-1);
                end else if (backspace) begin
                    if (count != '0) begin
                        for (int k = 0; k < NDIG-1; k++) digit_array[k] <= digit_array[k+1];
                        digit_array[NDIG-1] <= BLANK;
                        count <= count - 1'b1;
                    end
                end else if (digit_valid) begin
                    if (digit_in <= 4'd9 && count < CW'(NDIG)) begin
                        for (int k = NDIG-1; k > 0; k--) digit_array[k] <= digit_array[k-1];
                        digit_array[0] <= digit_in;
                        count <= count + 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                end
            end else begin
                acc <= acc_next;
                idx <= idx - 1'b1;
                if (last) begin
`ifdef DIGITS_TO_NUM_SENTINEL_EN
                    // count cannot change during CONV, so it still reflects the converted buffer.
                    number <= (count == '0) ? WIDTH'(NUM_WAIT) : acc_next;
`else
                    number <= acc_next;
`endif
                    num_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_digits_to_num.sv
// Bench for digits_to_num: vector table, hand-written corner sequences, and random ops against a queue model.
module tb_digits_to_num;

    localparam int NDIG = 4;
`ifdef DIGITS_TO_NUM_SENTINEL_EN
    localparam logic [31:0] EMPTY_NUM = 32'hFFFF_FFFE;
`else
    localparam logic [31:0] EMPTY_NUM = 32'd0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       digit_in = '0;
    logic             digit_valid = 1'b0, backspace = 1'b0, clear = 1'b0, convert = 1'b0;
    logic [3:0][3:0]  digit_array;
    logic [2:0]       count;
    logic             busy, num_valid, err;
    logic [31:0]      number;

    int total = 0;
    int bad   = 0;

    digits_to_num dut (
        .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .digit_valid(digit_valid),
        .backspace(backspace), .clear(clear), .convert(convert),
        .digit_array(digit_array), .count(count), .busy(busy),
        .number(number), .num_valid(num_valid), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [3:0]  d [6];
        logic [15:0] arr;
        int          cnt;
        bit          e;
        logic [31:0] num;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enter(input logic [3:0] d);
        digit_in = d; digit_valid = 1'b1; tick(); digit_valid = 1'b0;
    endtask

    task automatic do_bs();
        backspace = 1'b1; tick(); backspace = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    // Called just after the convert edge; all strobes are dropped once num_valid is seen.
    task automatic wait_conv(input string nm, input logic [31:0] exp);
        int lat = 0, bc = 0;
        while (!num_valid && lat < 20) begin
            if (busy) bc++;
            tick();
            lat++;
        end
        digit_valid = 1'b0; backspace = 1'b0; convert = 1'b0; clear = 1'b0;
        check({nm, "_lat"}, lat, NDIG);
        check({nm, "_busy"}, bc, NDIG);
        check({nm, "_num"}, number, exp);
        tick();
        check({nm, "_pulse"}, num_valid, 1'b0);
    endtask

    task automatic run_conv(input string nm, input logic [31:0] exp);
        convert = 1'b1; tick(); convert = 1'b0;
        wait_conv(nm, exp);
    endtask

    // Reference model: q[0] is the most recent digit.
    int q[$];
    bit merr;

    function automatic logic [15:0] model_arr();
        logic [15:0] a;
        for (int k = 0; k < NDIG; k++) a[k*4 +: 4] = (k < q.size()) ? 4'(q[k]) : 4'hb;
        return a;
    endfunction

    function automatic logic [31:0] model_num();
        longint v = 0, p = 1;
        if (q.size() == 0) return EMPTY_NUM;
        foreach (q[i]) begin
            v += q[i] * p;
            p *= 10;
        end
        return 32'(v);
    endfunction

    vec_t vecs[6];

    initial begin
        vecs[0] = '{4, '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0}, 16'h1234, 4, 1'b0, 32'd1234};
        vecs[1] = '{1, '{4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 16'hBBB7, 1, 1'b0, 32'd7};
        vecs[2] = '{6, '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'hc}, 16'h9876, 4, 1'b1, 32'd9876};
        vecs[3] = '{3, '{4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 4'd0}, 16'hB005, 3, 1'b0, 32'd5};
        vecs[4] = '{0, '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 16'hBBBB, 0, 1'b0, EMPTY_NUM};
        vecs[5] = '{2, '{4'hc, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0}, 16'hBBB3, 1, 1'b1, 32'd3};

        #12;
        check("rst_arr", digit_array, 16'hBBBB);
        check("rst_cnt", count, 0);
        check("rst_num", number, 0);
        check("rst_nv", num_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            do_clear();
            check($sformatf("v%0d_clr_err", i), err, 0);
            check($sformatf("v%0d_clr_cnt", i), count, 0);
            for (int j = 0; j < vecs[i].n; j++) enter(vecs[i].d[j]);
            check($sformatf("v%0d_arr", i), digit_array, vecs[i].arr);
            check($sformatf("v%0d_cnt", i), count, vecs[i].cnt);
            check($sformatf("v%0d_err", i), err, vecs[i].e);
            run_conv($sformatf("v%0d", i), vecs[i].num);
            check($sformatf("v%0d_arr_kept", i), digit_array, vecs[i].arr);
            if (i == 1) run_conv("v1_again", 32'd7);
        end

        // Backspace mid-entry and at empty.
        do_clear();
        enter(4'd4); enter(4'd2); do_bs(); enter(4'd3);
        check("bs_arr", digit_array, 16'hBB43);
        run_conv("bs", 32'd43);
        do_clear();
        do_bs();
        check("bs0_cnt", count, 0);
        check("bs0_err", err, 0);
        check("bs0_arr", digit_array, 16'hBBBB);

        // Clear two cycles into a conversion.
        begin
            int seen = 0;
            enter(4'd5); enter(4'd5);
            convert = 1'b1; tick(); convert = 1'b0;
            tick();
            do_clear();
            check("abort_busy", busy, 0);
            repeat (8) begin
                if (num_valid) seen++;
                tick();
            end
            check("abort_nv", seen, 0);
            check("abort_num", number, 32'd43);
            check("abort_arr", digit_array, 16'hBBBB);
        end

        // Reset mid-conversion.
        enter(4'd5); enter(4'd5);
        convert = 1'b1; tick(); convert = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("mrst_arr", digit_array, 16'hBBBB);
        check("mrst_cnt", count, 0);
        check("mrst_num", number, 0);
        check("mrst_nv", num_valid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_err", err, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("mrst_nv2", num_valid, 0);

        // Same-cycle priority.
        enter(4'd3);
        clear = 1'b1; convert = 1'b1; tick(); clear = 1'b0; convert = 1'b0;
        check("pri_clr_busy", busy, 0);
        check("pri_clr_arr", digit_array, 16'hBBBB);
        enter(4'd1);
        convert = 1'b1; digit_valid = 1'b1; digit_in = 4'd2; tick();
        convert = 1'b0; digit_valid = 1'b0;
        wait_conv("pri_conv", 32'd1);
        check("pri_conv_arr", digit_array, 16'hBBB1);
        enter(4'd2);
        backspace = 1'b1; digit_valid = 1'b1; digit_in = 4'd5; tick();
        backspace = 1'b0; digit_valid = 1'b0;
        check("pri_bs_arr", digit_array, 16'hBBB1);

        // Strobes held during CONV are ignored.
        do_clear(); enter(4'd4);
        convert = 1'b1; digit_valid = 1'b1; digit_in = 4'hd; backspace = 1'b1;
        tick();
        wait_conv("hold", 32'd4);
        check("hold_arr", digit_array, 16'hBBB4);
        check("hold_err", err, 0);

        // Random operations against the queue model.
        do_clear();
        q.delete();
        merr = 1'b0;
        for (int it = 0; it < 400; it++) begin
            int r = $urandom_range(0, 99);
            if (r < 50) begin
                int d = $urandom_range(0, 11);
                enter(4'(d));
                if (d <= 9 && q.size() < NDIG) q.push_front(d);
                else merr = 1'b1;
            end else if (r < 65) begin
                do_bs();
                if (q.size() > 0) void'(q.pop_front());
            end else if (r < 70) begin
                do_clear();
                q.delete();
                merr = 1'b0;
            end else if (r < 80) begin
                run_conv($sformatf("rnd%0d", it), model_num());
            end else begin
                tick();
            end
            check($sformatf("rnd%0d_arr", it), digit_array, model_arr());
            check($sformatf("rnd%0d_cnt", it), count, q.size());
            check($sformatf("rnd%0d_err", it), err, merr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
